ncl_mult3_sync_bridge: RTL

Synchronous front/back end for the dual-rail 3×3 NCL multiplier. The bridge accepts binary operands over a valid/ready interface and encodes them into dual-rail DATA/NULL wavefronts. It runs the four-phase Ki/Ko handshake against the multiplier, synchronizes and completion-detects the asynchronous dual-rail product, and returns a binary 6-bit product over a valid/ready interface. It sits between clocked system logic and the multiplier's input and output ports, and owns the multiplier's active-high `rst`.

---
 rtl/ncl_mult3_sync_bridge.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ncl_mult3_sync_bridge.sv
// ncl_mult3_sync_bridge: clocked front/back end for the dual-rail 3x3 NCL
// multiplier. Binary operands become DATA/NULL wavefronts driven under the
// four-phase Ki/Ko protocol. The asynchronous dual-rail product is
// synchronized, completion-detected and returned as a binary product.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. in_ready never depends on in_valid. Once
// out_valid is raised, out_valid, out_p and out_err stay stable until that
// transfer happens, unless a new result is captured in the same cycle as
// the pop.
module ncl_mult3_sync_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int RST_HOLD    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_a,
    input  logic [2:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_p,
    output logic       out_err,
    output logic [2:0] mult_a_rail1,
    output logic [2:0] mult_a_rail0,
    output logic [2:0] mult_b_rail1,
    output logic [2:0] mult_b_rail0,
    output logic       mult_ki,
    output logic       mult_rst,
    input  logic       mult_ko,
    input  logic [5:0] mult_p_rail1,
    input  logic [5:0] mult_p_rail0
);

    localparam int         SW        = 13;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);
    localparam logic [7:0] SETTLE_C  = 8'(SYNC_STAGES);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_WAIT_NULL = 3'd3,
        ST_ABORT     = 3'd4
    } state_t;

    // Synchronizer chain: bit 12 = Ko, bits 11:6 = rail1, bits 5:0 = rail0.
    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic [SW-1:0] sync_d [SYNC_STAGES];

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       from_hold_q, from_hold_d;
    logic [2:0] a_rail1_q, a_rail1_d, a_rail0_q, a_rail0_d;
    logic [2:0] b_rail1_q, b_rail1_d, b_rail0_q, b_rail0_d;
    logic       ki_q, ki_d;
    logic       mrst_q, mrst_d;
    logic       out_valid_q, out_valid_d;
    logic [5:0] out_p_q, out_p_d;
    logic       out_err_q, out_err_d;

    logic       ko_s;
    logic [5:0] p1_s, p0_s;
    logic       p_complete, p_null, p_illegal;
    logic       hold_free, accept, cap_ok, cap_err;

    // Shift the raw multiplier signals through the synchronizer stages.
    always_comb begin
        sync_d[0] = {mult_ko, mult_p_rail1, mult_p_rail0};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchronizer flops, cleared by reset like every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    assign ko_s       = sync_q[SYNC_STAGES-1][12];
    assign p1_s       = sync_q[SYNC_STAGES-1][11:6];
    assign p0_s       = sync_q[SYNC_STAGES-1][5:0];
    assign p_complete = &(p1_s ^ p0_s);
    assign p_null     = ~|{p1_s, p0_s};
    assign p_illegal  = |(p1_s & p0_s);

    // The holding register can take a result if it is empty or popping now.
    assign hold_free = ~out_valid_q | out_ready;

    // After a multiplier reset, wait SYNC_STAGES cycles in IDLE before
    // trusting Ko/NULL, so the synchronizers reflect post-reset values.
    assign in_ready = (state_q == ST_IDLE) && ko_s && p_null &&
                      (!from_hold_q || (cnt_q >= SETTLE_C));

    // Next-state logic and per-transition events.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        cap_ok  = 1'b0;
        cap_err = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q >= HOLD_LAST) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (p_illegal) begin
                    state_d = ST_ABORT;
                end else if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (p_illegal) begin
                    state_d = ST_ABORT;
                end else if (p_complete && !ko_s && hold_free) begin
                    cap_ok  = 1'b1;
                    state_d = ST_WAIT_NULL;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = ST_ABORT;
                end
            end
            ST_WAIT_NULL: begin
                if (p_illegal) begin
                    state_d = ST_ABORT;
                end else if (p_null && ko_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (hold_free) begin
                    cap_err = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    // Wait counter, settle flag, rails, Ki/rst and the result holding register.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == TIMEOUT_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        if (state_q == ST_HOLD) begin
            from_hold_d = 1'b1;
        end else if (state_q == ST_IDLE) begin
            from_hold_d = from_hold_q;
        end else begin
            from_hold_d = 1'b0;
        end

        a_rail1_d = a_rail1_q;
        a_rail0_d = a_rail0_q;
        b_rail1_d = b_rail1_q;
        b_rail0_d = b_rail0_q;
        if (accept) begin
            a_rail1_d = in_a;
            a_rail0_d = ~in_a;
            b_rail1_d = in_b;
            b_rail0_d = ~in_b;
        end else if (state_d != ST_WAIT_DATA) begin
            a_rail1_d = '0;
            a_rail0_d = '0;
            b_rail1_d = '0;
            b_rail0_d = '0;
        end

        ki_d   = (state_d == ST_IDLE) || (state_d == ST_WAIT_DATA);
        mrst_d = (state_d == ST_HOLD);

        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
        out_err_d   = out_err_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (cap_ok) begin
            out_valid_d = 1'b1;
            out_p_d     = p1_s;
            out_err_d   = 1'b0;
        end else if (cap_err) begin
            out_valid_d = 1'b1;
            out_p_d     = '0;
            out_err_d   = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            from_hold_q <= 1'b0;
            a_rail1_q   <= '0;
            a_rail0_q   <= '0;
            b_rail1_q   <= '0;
            b_rail0_q   <= '0;
            ki_q        <= 1'b0;
            mrst_q      <= 1'b1;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            from_hold_q <= from_hold_d;
            a_rail1_q   <= a_rail1_d;
            a_rail0_q   <= a_rail0_d;
            b_rail1_q   <= b_rail1_d;
            b_rail0_q   <= b_rail0_d;
            ki_q        <= ki_d;
            mrst_q      <= mrst_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
            out_err_q   <= out_err_d;
        end
    end

    assign mult_a_rail1 = a_rail1_q;
    assign mult_a_rail0 = a_rail0_q;
    assign mult_b_rail1 = b_rail1_q;
    assign mult_b_rail0 = b_rail0_q;
    assign mult_ki      = ki_q;
    assign mult_rst     = mrst_q;
    assign out_valid    = out_valid_q;
    assign out_p        = out_p_q;
    assign out_err      = out_err_q;

endmodule
